// File: rtl/hangman_word_datapath.sv
// hangman_word_datapath: secret-word store and serial guess scanner for the
// hangman game. The control FSM loads the word with ld, freezes it with lock,
// then issues compare/fill pairs; the scan visits one position per clock.
// Optional build macro: CASE_FOLD_EN folds 'a'..'z' to upper case before
// storing or comparing, so 'a' matches 'A'.
module hangman_word_datapath #(
  parameter int MAX_LEN = 16,
  parameter int CHAR_W  = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld,
  input  logic [CHAR_W-1:0]  char_in,
  input  logic               lock,
  input  logic               compare,
  input  logic [CHAR_W-1:0]  guess,
  input  logic               fill,
  input  logic               wipe,
  output logic [4:0]         wordcount,
  output logic [4:0]         remain,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [4:0]         count,
  output logic               dup,
  output logic [MAX_LEN-1:0] revealed,
  output logic               all_found
);

  localparam int         IW      = $clog2(MAX_LEN);
  localparam logic [4:0] MAX_CNT = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_READY,
    S_SCAN,
    S_RESULT
  } state_t;

  state_t             state, state_nxt;
  logic [CHAR_W-1:0]  store_q [MAX_LEN];
  logic [CHAR_W-1:0]  guess_q;
  logic [MAX_LEN-1:0] hit;
  logic [IW-1:0]      idx;
  logic               seen;
  logic               fill_pend;   // a result is waiting to be revealed by fill

  logic lock_ok, ld_ok, fill_ok, scan_eq, scan_last;

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
`ifdef CASE_FOLD_EN
    if (c >= CHAR_W'(8'h61) && c <= CHAR_W'(8'h7A)) return c - CHAR_W'(8'h20);
`endif
    return c;
  endfunction

  // lock wins over a simultaneous ld so remain always equals the locked length.
  assign lock_ok   = lock && (wordcount != 5'd0);
  assign ld_ok     = ld && !lock_ok && (wordcount != MAX_CNT);
  assign fill_ok   = fill && fill_pend;
  assign scan_eq   = (store_q[idx] == guess_q);
  assign scan_last = (5'(idx) == wordcount - 5'd1);

  assign busy      = (state == S_SCAN);
  assign all_found = (state != S_ENTRY) && (remain == 5'd0);

  // State register.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= S_ENTRY;
    else        state <= state_nxt;
  end

  // Next-state logic; wipe overrides every other strobe.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_ENTRY:  if (lock_ok) state_nxt = S_READY;
      S_READY:  if (compare) state_nxt = S_SCAN;
      S_SCAN:   if (scan_last) state_nxt = S_RESULT;
      S_RESULT: state_nxt = S_READY;
      default:  state_nxt = S_ENTRY;
    endcase
    if (wipe) state_nxt = S_ENTRY;
  end

  // Word store, scan accumulators, result flags and reveal bookkeeping.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      // NOTE: the character store is a small flop array, so it is cleared on reset like any other register.
      for (int i = 0; i < MAX_LEN; i++) store_q[i] <= '0;
      wordcount <= '0;
      remain    <= '0;
      count     <= '0;
      match     <= 1'b0;
      dup       <= 1'b0;
      done      <= 1'b0;
      revealed  <= '0;
      hit       <= '0;
      guess_q   <= '0;
      idx       <= '0;
      seen      <= 1'b0;
      fill_pend <= 1'b0;
    end else if (wipe) begin
      wordcount <= '0;
      remain    <= '0;
      count     <= '0;
      match     <= 1'b0;
      dup       <= 1'b0;
      done      <= 1'b0;
      revealed  <= '0;
      hit       <= '0;
      idx       <= '0;
      seen      <= 1'b0;
      fill_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later writes in this block override earlier ones.
      done <= 1'b0;
      case (state)
        S_ENTRY: begin
          if (ld_ok) begin
            store_q[wordcount[IW-1:0]] <= fold(char_in);
            wordcount                  <= wordcount + 5'd1;
          end
          if (lock_ok) remain <= wordcount;
        end
        S_READY: begin
          // fill is applied first; a simultaneous compare then restarts the accumulators.
          if (fill_ok) begin
            revealed  <= revealed | hit;
            remain    <= remain - count;
            hit       <= '0;
            fill_pend <= 1'b0;
          end
          if (compare) begin
            guess_q   <= fold(guess);
            count     <= '0;
            match     <= 1'b0;
            dup       <= 1'b0;
            hit       <= '0;
            seen      <= 1'b0;
            idx       <= '0;
            fill_pend <= 1'b0;
          end
        end
        S_SCAN: begin
          if (scan_eq) begin
            if (!revealed[idx]) begin
              count    <= count + 5'd1;
              hit[idx] <= 1'b1;
            end else begin
              seen <= 1'b1;
            end
          end
          idx <= idx + 1'b1;
        end
        S_RESULT: begin
          done      <= 1'b1;
          match     <= (count != 5'd0);
          dup       <= (count == 5'd0) && seen;
          fill_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hangman_word_datapath.sv
// Self-checking bench for hangman_word_datapath: directed scenarios plus random
// words and guesses, all compared with a position-list reference model.
module tb_hangman_word_datapath;

  localparam int MAX_LEN = 16;
  localparam int CHAR_W  = 8;

  logic              clk = 1'b0;
  logic              resetn, ld, lock, compare, fill, wipe;
  logic [CHAR_W-1:0] char_in, guess;
  logic [4:0]        wordcount, remain, count;
  logic              busy, done, match, dup, all_found;
  logic [MAX_LEN-1:0] revealed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hangman_word_datapath #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W)) dut (
    .clk(clk), .resetn(resetn), .ld(ld), .char_in(char_in), .lock(lock),
    .compare(compare), .guess(guess), .fill(fill), .wipe(wipe),
    .wordcount(wordcount), .remain(remain), .busy(busy), .done(done),
    .match(match), .count(count), .dup(dup), .revealed(revealed),
    .all_found(all_found)
  );

  // Reference model: the word as a list of characters plus per-position flags.
  byte unsigned       mw[$];
  logic [MAX_LEN-1:0] mrev, mhit;
  int                 mremain, mcnt;
  bit                 mfill_ok, mlocked, mseen;

  function automatic logic [7:0] ref_fold(input logic [7:0] c);
`ifdef CASE_FOLD_EN
    if (c >= "a" && c <= "z") return c - 8'h20;
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mw.delete();
    mrev = '0; mhit = '0; mremain = 0; mcnt = 0;
    mfill_ok = 0; mlocked = 0; mseen = 0;
  endtask

  task automatic model_fill();
    if (mfill_ok) begin
      mrev     = mrev | mhit;
      mremain  = mremain - mcnt;
      mhit     = '0;
      mfill_ok = 0;
    end
  endtask

  task automatic load_word(input string s);
    for (int i = 0; i < s.len(); i++) begin
      char_in = s[i]; ld = 1'b1;
      tick();
      ld = 1'b0;
      if (!mlocked && mw.size() < MAX_LEN) mw.push_back(s[i]);
    end
  endtask

  task automatic lock_word();
    lock = 1'b1;
    tick();
    lock = 1'b0;
    if (!mlocked && mw.size() > 0) begin
      mlocked = 1;
      mremain = mw.size();
    end
  endtask

  task automatic do_wipe();
    wipe = 1'b1;
    tick();
    wipe = 1'b0;
    model_reset();
  endtask

  // Issue one guess (optionally with a same-cycle fill) and check its result.
  task automatic do_guess(input logic [7:0] g, input bit with_fill);
    int cyc, busy_cyc, n;
    if (with_fill) model_fill();
    n = mw.size();
    mcnt = 0; mseen = 0; mhit = '0;
    for (int i = 0; i < n; i++)
      if (ref_fold(mw[i]) == ref_fold(g)) begin
        if (!mrev[i]) begin mcnt++; mhit[i] = 1'b1; end
        else mseen = 1;
      end
    mfill_ok = 0;
    guess = g; compare = 1'b1; fill = with_fill;
    tick();
    compare = 1'b0; fill = 1'b0;
    if (with_fill) begin
      checks++;
      if (revealed !== mrev || remain !== 5'(mremain)) begin
        errors++;
        $display("FAIL guess_fill_same_cycle revealed=%h remain=%0d expected revealed=%h remain=%0d",
                 revealed, remain, mrev, mremain);
      end
    end
    cyc = 0; busy_cyc = 0;
    while (done !== 1'b1 && cyc < 64) begin
      if (busy === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout guess=%h waited %0d cycles, expected done after %0d", g, cyc, n + 1);
    end else if (cyc != n + 1 || busy_cyc != n) begin
      errors++;
      $display("FAIL latency guess=%h done_after=%0d busy=%0d expected done_after=%0d busy=%0d",
               g, cyc, busy_cyc, n + 1, n);
    end
    checks++;
    if (match !== (mcnt != 0) || count !== 5'(mcnt) || dup !== (mcnt == 0 && mseen)) begin
      errors++;
      $display("FAIL result guess=%h match=%b count=%0d dup=%b expected match=%b count=%0d dup=%b",
               g, match, count, dup, mcnt != 0, mcnt, mcnt == 0 && mseen);
    end
    mfill_ok = 1;
    tick();
    checks++;
    if (done !== 1'b0 || count !== 5'(mcnt) || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse guess=%h done=%b count=%0d busy=%b expected done=0 count=%0d busy=0",
               g, done, count, busy, mcnt);
    end
  endtask

  task automatic do_fill();
    model_fill();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    checks++;
    if (revealed !== mrev || remain !== 5'(mremain) || all_found !== (mlocked && mremain == 0)) begin
      errors++;
      $display("FAIL fill revealed=%h remain=%0d all_found=%b expected revealed=%h remain=%0d all_found=%b",
               revealed, remain, all_found, mrev, mremain, mlocked && mremain == 0);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; ld = 0; lock = 0; compare = 0; fill = 0; wipe = 0;
    char_in = '0; guess = '0;
    model_reset();
    tick(); tick();
    resetn = 1'b0;
    tick();
    checks++;
    if ({wordcount, remain, count} !== 15'd0 || {busy, done, match, dup, all_found} !== 5'd0 ||
        revealed !== '0) begin
      errors++;
      $display("FAIL reset wc=%0d remain=%0d count=%0d flags=%b revealed=%h expected all zero",
               wordcount, remain, count, {busy, done, match, dup, all_found}, revealed);
    end
  endtask

  // Empty lock and compare in entry must both be ignored.
  task automatic test_ignored_strobes();
    lock_word();
    compare = 1'b1; guess = "A";
    tick();
    compare = 1'b0;
    checks++;
    if (busy !== 1'b0 || all_found !== 1'b0 || wordcount !== 5'd0) begin
      errors++;
      $display("FAIL empty_lock busy=%b all_found=%b wc=%0d expected 0 0 0", busy, all_found, wordcount);
    end
  endtask

  task automatic test_hello();
    load_word("HELLO");
    lock_word();
    checks++;
    if (wordcount !== 5'd5 || remain !== 5'd5 || revealed !== '0 || all_found !== 1'b0) begin
      errors++;
      $display("FAIL hello_lock wc=%0d remain=%0d revealed=%h all_found=%b expected 5 5 0 0",
               wordcount, remain, revealed, all_found);
    end
    load_word("X");  // ld after lock is ignored
    checks++;
    if (wordcount !== 5'd5) begin
      errors++;
      $display("FAIL ld_after_lock wc=%0d expected 5", wordcount);
    end
    do_guess("L", 0);
    do_fill();
    checks++;
    if (revealed !== 16'h000C || remain !== 5'd3) begin
      errors++;
      $display("FAIL hello_L revealed=%h remain=%0d expected 000c 3", revealed, remain);
    end
    do_guess("L", 0);
    checks++;
    if (match !== 1'b0 || dup !== 1'b1) begin
      errors++;
      $display("FAIL hello_dup match=%b dup=%b expected 0 1", match, dup);
    end
    do_guess("Z", 0);
    do_fill();
    do_guess("H", 0); do_fill();
    do_guess("E", 0); do_fill();
    do_guess("O", 0); do_fill();
    checks++;
    if (revealed !== 16'h001F || remain !== 5'd0 || all_found !== 1'b1) begin
      errors++;
      $display("FAIL hello_done revealed=%h remain=%0d all_found=%b expected 001f 0 1",
               revealed, remain, all_found);
    end
    do_fill();  // second fill without compare changes nothing
  endtask

  task automatic test_wipe_mid_scan();
    do_wipe();
    load_word("ABCDEF");
    lock_word();
    do_guess("B", 0);
    do_fill();
    guess = "A"; compare = 1'b1;
    tick();
    compare = 1'b0;
    tick(); tick();
    do_wipe();
    checks++;
    if ({wordcount, remain, count} !== 15'd0 || {busy, done, match, dup, all_found} !== 5'd0 ||
        revealed !== '0) begin
      errors++;
      $display("FAIL wipe wc=%0d remain=%0d count=%0d flags=%b revealed=%h expected all zero",
               wordcount, remain, count, {busy, done, match, dup, all_found}, revealed);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL wipe_no_done cycle=%0d done=%b expected 0", i, done);
      end
      tick();
    end
    load_word("Q");
    checks++;
    if (wordcount !== 5'd1) begin
      errors++;
      $display("FAIL ld_after_wipe wc=%0d expected 1", wordcount);
    end
  endtask

  task automatic test_overflow();
    do_wipe();
    load_word("ABCDEFGHIJKLMNOPZ");
    checks++;
    if (wordcount !== 5'd16) begin
      errors++;
      $display("FAIL overflow wc=%0d expected 16", wordcount);
    end
    lock_word();
    do_guess("Z", 0);
    do_guess("P", 0);
    do_fill();
  endtask

  task automatic test_case_fold();
    bit exp_match;
`ifdef CASE_FOLD_EN
    exp_match = 1;
`else
    exp_match = 0;
`endif
    do_wipe();
    load_word("Ab");
    lock_word();
    do_guess("a", 0);
    checks++;
    if (match !== exp_match) begin
      errors++;
      $display("FAIL case_fold match=%b expected %b", match, exp_match);
    end
    do_fill();
  endtask

  task automatic test_random();
    string alpha = "ABCDab";
    string gs    = "ABCDEab";
    for (int r = 0; r < 8; r++) begin
      int len;
      string w;
      do_wipe();
      len = $urandom_range(2, MAX_LEN);
      w = "";
      for (int i = 0; i < len; i++) w = {w, string'(alpha[$urandom_range(0, 5)])};
      load_word(w);
      lock_word();
      checks++;
      if (wordcount !== 5'(len) || remain !== 5'(len)) begin
        errors++;
        $display("FAIL rand_lock wc=%0d remain=%0d expected %0d", wordcount, remain, len);
      end
      for (int k = 0; k < 30 && all_found !== 1'b1; k++) begin
        do_guess(gs[$urandom_range(0, 6)], $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) != 0) do_fill();
        if ($urandom_range(0, 7) == 0) do_fill();
      end
    end
  endtask

  initial begin
    test_reset();
    test_ignored_strobes();
    test_hello();
    test_wipe_mid_scan();
    test_overflow();
    test_case_fold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
